// File: rtl/cache_set_array_pkg.sv
// Shared L1 model types: MESI state, array operation codes and the default-width line record.
package my_struct_package;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_FILL   = 2'd1,
        OP_UPDATE = 2'd2,
        OP_CLEAR  = 2'd3
    } cache_op_t;

    localparam int LINE_TAG_W  = 12;
    localparam int LINE_DATA_W = 32;
    localparam int LINE_WAY_W  = 3;

    // Packages cannot be parameterised, so the array builds its own view with the same field order.
    typedef struct packed {
        logic [LINE_WAY_W-1:0]  lru;
        mesi_t                  mesi;
        logic [LINE_TAG_W-1:0]  tag;
        logic [LINE_DATA_W-1:0] data;
    } cache_line_t;

endpackage

// File: rtl/cache_set_array_lru_update.sv
// Combinational LRU counter update for one set: promote to MRU or demote to LRU.
// Counters stay a permutation of 0..WAYS-1 when the input is one.
module cache_lru_update #(
    parameter int WAYS  = 8,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS*WAY_W-1:0] lru_in,
    input  logic [WAY_W-1:0]      way,
    input  logic                  promote,
    output logic [WAYS*WAY_W-1:0] lru_out
);

    logic [WAY_W-1:0] cur;

    always_comb begin
        cur     = lru_in[int'(way)*WAY_W +: WAY_W];
        lru_out = lru_in;
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == way)
                lru_out[i*WAY_W +: WAY_W] = promote ? WAY_W'(WAYS-1) : '0;
            else if (promote && (lru_in[i*WAY_W +: WAY_W] > cur))
                lru_out[i*WAY_W +: WAY_W] = lru_in[i*WAY_W +: WAY_W] - 1'b1;
            else if (!promote && (lru_in[i*WAY_W +: WAY_W] < cur))
                lru_out[i*WAY_W +: WAY_W] = lru_in[i*WAY_W +: WAY_W] + 1'b1;
        end
    end

endmodule

// File: rtl/cache_set_array.sv
// Set-associative tag/state/data array with LRU; one request per cycle, response one cycle later.
// req_ready is low only while sweeping sets to invalid (after reset or CLEAR).
module cache_set_array
    import my_struct_package::*;
#(
    parameter int SETS   = 16384,
    parameter int WAYS   = 8,
    parameter int TAG_W  = 12,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(SETS),
    parameter int WAY_W  = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  cache_op_t         req_op,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [WAY_W-1:0]  req_way,
    input  mesi_t             req_mesi,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [WAY_W-1:0]  rsp_way,
    output mesi_t             rsp_mesi,
    output logic [DATA_W-1:0] rsp_data,
    output logic [WAY_W-1:0]  rsp_victim_way,
    output logic [TAG_W-1:0]  rsp_victim_tag,
    output mesi_t             rsp_victim_mesi
);

    typedef struct packed {
        logic [WAY_W-1:0]  lru;
        mesi_t             mesi;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       sweep_idx;
    logic                   clear_sweep;
    line_t [WAYS-1:0]       mem [SETS];
    line_t [WAYS-1:0]       rd_set, upd_set, sweep_set, wr_set;
    logic [IDX_W-1:0]       wr_idx;
    logic                   wr_en;
    logic                   accept, hit, inv_found, apply_lru, hit_c;
    logic [WAY_W-1:0]       hit_way, vic_inv, vic_lru, victim, tgt;
    logic [WAYS*WAY_W-1:0]  lru_old, lru_new;

    assign rd_set = mem[req_index];
    assign accept = req_valid && req_ready;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vic_inv   = '0;
        vic_lru   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (rd_set[i].mesi != MESI_I && rd_set[i].tag == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (rd_set[i].mesi == MESI_I && !inv_found) begin
                inv_found = 1'b1;
                vic_inv   = WAY_W'(i);
            end
            if (rd_set[i].lru == '0)
                vic_lru = WAY_W'(i);
        end
        victim = inv_found ? vic_inv : vic_lru;
        tgt    = (req_op == OP_UPDATE) ? req_way : (hit ? hit_way : victim);
        hit_c  = (req_op == OP_UPDATE) ? (rd_set[req_way].mesi != MESI_I) : hit;
        for (int i = 0; i < WAYS; i++)
            lru_old[i*WAY_W +: WAY_W] = rd_set[i].lru;
    end

    cache_lru_update #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
        .lru_in  (lru_old),
        .way     (tgt),
        .promote (req_op != OP_UPDATE),
        .lru_out (lru_new)
    );

    always_comb begin
        upd_set   = rd_set;
        apply_lru = 1'b0;
        case (req_op)
            OP_LOOKUP: apply_lru = hit;
            OP_FILL: begin
                upd_set[tgt].tag  = req_tag;
                upd_set[tgt].data = req_data;
                upd_set[tgt].mesi = req_mesi;
                apply_lru         = 1'b1;
            end
            OP_UPDATE: begin
                upd_set[tgt].mesi = req_mesi;
                upd_set[tgt].data = req_data;
                // Snoop-driven updates leave recency alone unless the line is being dropped.
                apply_lru         = (req_mesi == MESI_I);
            end
            default: ;
        endcase
        if (apply_lru)
            for (int i = 0; i < WAYS; i++)
                upd_set[i].lru = lru_new[i*WAY_W +: WAY_W];
    end

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            sweep_set[i].lru  = WAY_W'(i);
            sweep_set[i].mesi = MESI_I;
            sweep_set[i].tag  = '0;
            sweep_set[i].data = '0;
        end
        wr_en  = 1'b0;
        wr_idx = req_index;
        wr_set = upd_set;
        if (rst_n) begin
            if (state == SWEEP) begin
                wr_en  = 1'b1;
                wr_idx = sweep_idx;
                wr_set = sweep_set;
            end else if (accept && req_op != OP_CLEAR) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk)
        if (wr_en)
            mem[wr_idx] <= wr_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= SWEEP;
            sweep_idx       <= '0;
            clear_sweep     <= 1'b0;
            req_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_hit         <= 1'b0;
            rsp_way         <= '0;
            rsp_mesi        <= MESI_I;
            rsp_data        <= '0;
            rsp_victim_way  <= '0;
            rsp_victim_tag  <= '0;
            rsp_victim_mesi <= MESI_I;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                SWEEP: begin
                    sweep_idx <= sweep_idx + IDX_W'(1);
                    if (sweep_idx == IDX_W'(SETS-1)) begin
                        state       <= IDLE;
                        req_ready   <= 1'b1;
                        clear_sweep <= 1'b0;
                        if (clear_sweep) begin
                            rsp_valid       <= 1'b1;
                            rsp_hit         <= 1'b0;
                            rsp_way         <= '0;
                            rsp_mesi        <= MESI_I;
                            rsp_data        <= '0;
                            rsp_victim_way  <= '0;
                            rsp_victim_tag  <= '0;
                            rsp_victim_mesi <= MESI_I;
                        end
                    end
                end
                IDLE: begin
                    if (accept && req_op == OP_CLEAR) begin
                        state       <= SWEEP;
                        sweep_idx   <= '0;
                        clear_sweep <= 1'b1;
                        req_ready   <= 1'b0;
                    end else if (accept) begin
                        rsp_valid       <= 1'b1;
                        rsp_hit         <= hit_c;
                        rsp_way         <= tgt;
                        rsp_mesi        <= upd_set[tgt].mesi;
                        rsp_data        <= upd_set[tgt].data;
                        rsp_victim_way  <= victim;
                        rsp_victim_tag  <= rd_set[victim].tag;
                        rsp_victim_mesi <= rd_set[victim].mesi;
                    end
                end
                default: state <= SWEEP;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_set_array.sv
// Directed bench for cache_set_array with SETS=4, WAYS=4; expected values computed by hand.
module tb_cache_set_array;
    import my_struct_package::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    cache_op_t   req_op;
    logic [1:0]  req_index;
    logic [11:0] req_tag;
    logic [1:0]  req_way;
    mesi_t       req_mesi;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [1:0]  rsp_way;
    mesi_t       rsp_mesi;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_victim_way;
    logic [11:0] rsp_victim_tag;
    mesi_t       rsp_victim_mesi;

    int checks = 0;
    int errors = 0;
    int n;
    int pulses;

    always #5 clk = ~clk;

    cache_set_array #(.SETS(4), .WAYS(4), .TAG_W(12), .DATA_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_index       (req_index),
        .req_tag         (req_tag),
        .req_way         (req_way),
        .req_mesi        (req_mesi),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_hit         (rsp_hit),
        .rsp_way         (rsp_way),
        .rsp_mesi        (rsp_mesi),
        .rsp_data        (rsp_data),
        .rsp_victim_way  (rsp_victim_way),
        .rsp_victim_tag  (rsp_victim_tag),
        .rsp_victim_mesi (rsp_victim_mesi)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic rq(input cache_op_t op, input logic [1:0] idx, input logic [11:0] tag,
                      input logic [1:0] way, input mesi_t mesi, input logic [31:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_index = idx;
        req_tag   = tag;
        req_way   = way;
        req_mesi  = mesi;
        req_data  = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic chk_rsp(input string name, input logic hit, input logic [1:0] way,
                           input mesi_t mesi, input logic [31:0] data);
        chk({name, ".valid"}, rsp_valid, 1'b1);
        chk({name, ".hit"},   rsp_hit,   hit);
        chk({name, ".way"},   rsp_way,   way);
        chk({name, ".mesi"},  rsp_mesi,  mesi);
        chk({name, ".data"},  rsp_data,  data);
    endtask

    task automatic chk_vic(input string name, input logic [1:0] way, input logic [11:0] tag,
                           input mesi_t mesi);
        chk({name, ".vway"},  rsp_victim_way,  way);
        chk({name, ".vtag"},  rsp_victim_tag,  tag);
        chk({name, ".vmesi"}, rsp_victim_mesi, mesi);
    endtask

    // Counts not-ready cycles until req_ready rises and the rsp_valid pulses seen on the way.
    task automatic wait_ready(output int cycles, output int pls);
        cycles = 0;
        pls    = 0;
        while (!req_ready && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (rsp_valid) pls++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_LOOKUP;
        req_index = '0;
        req_tag   = '0;
        req_way   = '0;
        req_mesi  = MESI_I;
        req_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.ready", req_ready, 1'b0);
        chk("reset.rsp_valid", rsp_valid, 1'b0);
        chk("reset.rsp_fields", {rsp_hit, rsp_way, rsp_mesi, rsp_data}, '0);
        chk("reset.victim", {rsp_victim_way, rsp_victim_tag, rsp_victim_mesi}, '0);
        rst_n = 1'b1;
        wait_ready(n, pulses);
        chk("reset.sweep_len", n, 4);
        chk("reset.sweep_pulses", pulses, 0);

        rq(OP_LOOKUP, 2'd2, 12'h0AB, 2'd0, MESI_I, 32'h0);
        chk_rsp("lookup_empty", 1'b0, 2'd0, MESI_I, 32'h0);
        chk_vic("lookup_empty", 2'd0, 12'h000, MESI_I);

        for (int i = 0; i < 4; i++) begin
            rq(OP_FILL, 2'd1, 12'h100 + 12'(i), 2'd0, MESI_E, 32'hA0 + 32'(i));
            chk_rsp($sformatf("fill%0d", i), 1'b0, 2'(i), MESI_E, 32'hA0 + 32'(i));
        end

        rq(OP_LOOKUP, 2'd1, 12'h102, 2'd0, MESI_I, 32'h0);
        chk_rsp("lookup_102", 1'b1, 2'd2, MESI_E, 32'hA2);
        @(posedge clk);
        #1;
        chk("hold.valid", rsp_valid, 1'b0);
        chk("hold.data", rsp_data, 32'hA2);

        rq(OP_FILL, 2'd1, 12'h104, 2'd0, MESI_E, 32'hA4);
        chk_rsp("fill_104", 1'b0, 2'd0, MESI_E, 32'hA4);
        chk_vic("fill_104", 2'd0, 12'h100, MESI_E);

        rq(OP_UPDATE, 2'd1, 12'h000, 2'd3, MESI_I, 32'h0);
        chk_rsp("inval_w3", 1'b1, 2'd3, MESI_I, 32'h0);
        chk_vic("inval_w3", 2'd1, 12'h101, MESI_E);

        rq(OP_LOOKUP, 2'd1, 12'h103, 2'd0, MESI_I, 32'h0);
        chk_rsp("lookup_103", 1'b0, 2'd3, MESI_I, 32'h0);
        chk("lookup_103.vway", rsp_victim_way, 2'd3);

        rq(OP_FILL, 2'd0, 12'h055, 2'd0, MESI_S, 32'h55);
        chk_rsp("b2b_fill", 1'b0, 2'd0, MESI_S, 32'h55);
        rq(OP_LOOKUP, 2'd0, 12'h055, 2'd0, MESI_I, 32'h0);
        chk_rsp("b2b_lookup", 1'b1, 2'd0, MESI_S, 32'h55);

        rq(OP_FILL, 2'd1, 12'h101, 2'd0, MESI_M, 32'hBB);
        chk_rsp("dup_fill", 1'b1, 2'd1, MESI_M, 32'hBB);
        chk_vic("dup_fill", 2'd3, 12'h103, MESI_I);
        rq(OP_LOOKUP, 2'd1, 12'h104, 2'd0, MESI_I, 32'h0);
        chk_rsp("dup_w0", 1'b1, 2'd0, MESI_E, 32'hA4);
        rq(OP_LOOKUP, 2'd1, 12'h102, 2'd0, MESI_I, 32'h0);
        chk_rsp("dup_w2", 1'b1, 2'd2, MESI_E, 32'hA2);

        rq(OP_CLEAR, 2'd0, 12'h000, 2'd0, MESI_I, 32'h0);
        chk("clear.accept_valid", rsp_valid, 1'b0);
        chk("clear.accept_ready", req_ready, 1'b0);
        wait_ready(n, pulses);
        chk("clear.sweep_len", n, 4);
        chk("clear.pulses", pulses, 1);
        chk("clear.rsp_valid", rsp_valid, 1'b1);
        chk("clear.rsp_fields", {rsp_hit, rsp_way, rsp_mesi, rsp_data}, '0);
        @(posedge clk);
        #1;
        chk("clear.pulse_end", rsp_valid, 1'b0);

        rq(OP_LOOKUP, 2'd1, 12'h102, 2'd0, MESI_I, 32'h0);
        chk("after_clear.hit", rsp_hit, 1'b0);
        rq(OP_FILL, 2'd2, 12'h0AB, 2'd0, MESI_E, 32'h77);
        chk_rsp("refill", 1'b0, 2'd0, MESI_E, 32'h77);

        rq(OP_CLEAR, 2'd0, 12'h000, 2'd0, MESI_I, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midsweep_rst.ready", req_ready, 1'b0);
        chk("midsweep_rst.valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        wait_ready(n, pulses);
        chk("midsweep_rst.sweep_len", n, 4);
        chk("midsweep_rst.pulses", pulses, 0);

        rq(OP_LOOKUP, 2'd2, 12'h0AB, 2'd0, MESI_I, 32'h0);
        chk_rsp("final_set2", 1'b0, 2'd0, MESI_I, 32'h0);
        rq(OP_LOOKUP, 2'd0, 12'h055, 2'd0, MESI_I, 32'h0);
        chk("final_set0.hit", rsp_hit, 1'b0);
        rq(OP_LOOKUP, 2'd1, 12'h101, 2'd0, MESI_I, 32'h0);
        chk("final_set1.hit", rsp_hit, 1'b0);
        chk("final_set1.vway", rsp_victim_way, 2'd0);
        rq(OP_LOOKUP, 2'd3, 12'h000, 2'd0, MESI_I, 32'h0);
        chk("final_set3.hit", rsp_hit, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
